// File: rtl/avalon_bridge_pkg.sv
// Shared widths, FSM state encoding and the captured request record for the
// two-master Avalon bridge arbiter.
package avalon_bridge_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    // Arbiter FSM: wait for a request, own the slave bus, return the ack.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    // One master's request as presented on its port and replayed on s_*.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              rw;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/avalon_bridge_arbiter_rr.sv
// Two-way round-robin selector: a lone requester always wins; on contention
// the master that did not win last time is chosen.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Pure combinational pick, one-hot result (or zero when nobody asks).
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/avalon_bridge_arbiter.sv
// Two-master arbiter for the 16-bit Avalon bridge bus. Master 0 is the Nios
// bridge port, master 1 a hardware requester. The winning request is
// registered onto the shared slave bus; read data and a one-cycle ack go
// back to the winner. A watchdog completes transfers the slave never acks.
module avalon_bridge_arbiter
    import avalon_bridge_pkg::*;
#(
    parameter int                 TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]  ERR_DATA = 16'hDEAD
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_bus_enable,
    input  logic [BE_W-1:0]   m0_byte_enable,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic [DATA_W-1:0] m0_read_data,
    output logic              m0_acknowledge,
    output logic              m0_irq,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_bus_enable,
    input  logic [BE_W-1:0]   m1_byte_enable,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              m1_acknowledge,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_bus_enable,
    output logic [BE_W-1:0]   s_byte_enable,
    output logic              s_rw,
    output logic [DATA_W-1:0] s_write_data,
    input  logic [DATA_W-1:0] s_read_data,
    input  logic              s_acknowledge,
    input  logic              s_irq,

    output logic [1:0]        grant,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    req_t              req_arr [2];
    logic [1:0]        req_vec;
    logic [1:0]        pick;
    logic              pick_idx;

    state_e            state_reg;
    req_t              s_req_reg;
    logic              s_bus_enable_reg;
    logic [1:0]        grant_reg;
    logic              last_grant_reg;
    logic [1:0]        ack_reg;
    logic              timeout_err_reg;
    logic              irq_reg;
    logic [WD_W-1:0]   wd_reg;

    logic [WD_W-1:0]   wd_next;
    logic              wd_done;
    logic              busy;
    logic              rd_done;
    logic              timeout_hit;
    logic [DATA_W-1:0] rd_value;

    assign req_arr[0] = '{addr: m0_address, be: m0_byte_enable, rw: m0_rw, wdata: m0_write_data};
    assign req_arr[1] = '{addr: m1_address, be: m1_byte_enable, rw: m1_rw, wdata: m1_write_data};
    assign req_vec    = {m1_bus_enable, m0_bus_enable};

    rr_arbiter2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant_reg),
        .gnt        (pick)
    );

    assign pick_idx = pick[1];

    // Watchdog expires on the TIMEOUT-th BUSY cycle; a same-cycle ack wins.
    assign busy        = (state_reg == BUSY);
    assign wd_next     = wd_reg + WD_W'(1);
    assign wd_done     = (wd_next == WD_W'(TIMEOUT));
    assign rd_done     = busy && s_req_reg.rw && (s_acknowledge || wd_done);
    assign timeout_hit = busy && !s_acknowledge && wd_done;
    assign rd_value    = s_acknowledge ? s_read_data : ERR_DATA;

    // Main FSM: capture the winner, hold the slave bus, then pulse the ack.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg        <= IDLE;
            s_req_reg        <= '0;
            s_bus_enable_reg <= 1'b0;
            grant_reg        <= 2'b00;
            last_grant_reg   <= 1'b1;
            ack_reg          <= 2'b00;
            wd_reg           <= '0;
        end else begin
            ack_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        s_req_reg        <= req_arr[pick_idx];
                        s_bus_enable_reg <= 1'b1;
                        grant_reg        <= pick;
                        last_grant_reg   <= pick_idx;
                        wd_reg           <= '0;
                        state_reg        <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_acknowledge || wd_done) begin
                        ack_reg          <= grant_reg;
                        s_bus_enable_reg <= 1'b0;
                        state_reg        <= ACK;
                    end else begin
                        wd_reg <= wd_next;
                    end
                end
                ACK: begin
                    grant_reg <= 2'b00;
                    state_reg <= IDLE;
                end
                default: begin
                    grant_reg <= 2'b00;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Sticky watchdog flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            timeout_err_reg <= 1'b0;
        else if (timeout_hit)
            timeout_err_reg <= 1'b1;
        else if (err_clr)
            timeout_err_reg <= 1'b0;
    end

    // Slave interrupt retimed by one flop toward the Nios port.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            irq_reg <= 1'b0;
        else
            irq_reg <= s_irq;
    end

    // Per-master read-return register, updated only by that master's reads.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic [DATA_W-1:0] rdata_reg;
            // Latch slave data (or the error word) when this master's read completes.
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n)
                    rdata_reg <= '0;
                else if (rd_done && grant_reg[gi])
                    rdata_reg <= rd_value;
            end
        end
    endgenerate

    assign m0_read_data   = g_master[0].rdata_reg;
    assign m1_read_data   = g_master[1].rdata_reg;
    assign m0_acknowledge = ack_reg[0];
    assign m1_acknowledge = ack_reg[1];
    assign m0_irq         = irq_reg;

    assign s_address      = s_req_reg.addr;
    assign s_byte_enable  = s_req_reg.be;
    assign s_rw           = s_req_reg.rw;
    assign s_write_data   = s_req_reg.wdata;
    assign s_bus_enable   = s_bus_enable_reg;
    assign grant          = grant_reg;
    assign timeout_err    = timeout_err_reg;

endmodule

// File: tb/tb_avalon_bridge_arbiter.sv
// Directed bench for avalon_bridge_arbiter: a table of whole transactions
// (requests, slave response, expected bus fields / ack timing / read data),
// followed by hand-written sequences for the clear, stray ack, reset and irq.
module tb_avalon_bridge_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [10:0] m0_address, m1_address;
    logic        m0_bus_enable, m1_bus_enable;
    logic [1:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_rw, m1_rw;
    logic [15:0] m0_write_data, m1_write_data;
    logic [15:0] m0_read_data, m1_read_data;
    logic        m0_acknowledge, m1_acknowledge, m0_irq;
    logic [10:0] s_address;
    logic        s_bus_enable;
    logic [1:0]  s_byte_enable;
    logic        s_rw;
    logic [15:0] s_write_data;
    logic [15:0] s_read_data;
    logic        s_acknowledge, s_irq;
    logic [1:0]  grant;
    logic        timeout_err, err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    avalon_bridge_arbiter #(.TIMEOUT(8), .ERR_DATA(16'hDEAD)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_bus_enable(m0_bus_enable),
        .m0_byte_enable(m0_byte_enable), .m0_rw(m0_rw),
        .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
        .m0_acknowledge(m0_acknowledge), .m0_irq(m0_irq),
        .m1_address(m1_address), .m1_bus_enable(m1_bus_enable),
        .m1_byte_enable(m1_byte_enable), .m1_rw(m1_rw),
        .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
        .m1_acknowledge(m1_acknowledge),
        .s_address(s_address), .s_bus_enable(s_bus_enable),
        .s_byte_enable(s_byte_enable), .s_rw(s_rw),
        .s_write_data(s_write_data), .s_read_data(s_read_data),
        .s_acknowledge(s_acknowledge), .s_irq(s_irq),
        .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        string       name;
        logic        m0_req, m1_req;
        logic [10:0] m0_addr, m1_addr;
        logic [1:0]  m0_be, m1_be;
        logic        m0_rw, m1_rw;
        logic [15:0] m0_wd, m1_wd;
        logic        clr;
        int          ack_delay;     // BUSY cycles before the slave acks; -1 = never
        logic [15:0] slave_rd;
        logic [1:0]  exp_grant;
        logic [10:0] exp_addr;
        logic [1:0]  exp_be;
        logic        exp_rw;
        logic [15:0] exp_wd;
        int          exp_cycles;    // BUSY cycle in which completion is taken
        logic [15:0] exp_m0_rd, exp_m1_rd;
        logic        exp_terr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Apply one table entry; called in an IDLE cycle, 1 time unit after the edge.
    task automatic run_txn(input vec_t v);
        int  c;
        bit  got;
        m0_bus_enable = v.m0_req; m0_address = v.m0_addr; m0_byte_enable = v.m0_be;
        m0_rw = v.m0_rw; m0_write_data = v.m0_wd;
        m1_bus_enable = v.m1_req; m1_address = v.m1_addr; m1_byte_enable = v.m1_be;
        m1_rw = v.m1_rw; m1_write_data = v.m1_wd;
        err_clr = v.clr;
        tick();
        check({v.name, " s_bus_enable"}, 32'(s_bus_enable), 32'd1);
        check({v.name, " grant"}, 32'(grant), 32'(v.exp_grant));
        check({v.name, " s_address"}, 32'(s_address), 32'(v.exp_addr));
        check({v.name, " s_byte_enable"}, 32'(s_byte_enable), 32'(v.exp_be));
        check({v.name, " s_rw"}, 32'(s_rw), 32'(v.exp_rw));
        check({v.name, " s_write_data"}, 32'(s_write_data), 32'(v.exp_wd));
        c = 0;
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            s_acknowledge = (i == v.ack_delay + 1);
            s_read_data   = v.slave_rd;
            tick();
            s_acknowledge = 1'b0;
            if (m0_acknowledge || m1_acknowledge) begin
                c = i;
                got = 1;
                break;
            end
        end
        if (!got) $display("[TB] %s: no acknowledge within 20 cycles", v.name);
        check({v.name, " ack_cycle"}, 32'(c), 32'(v.exp_cycles));
        check({v.name, " ack_vec"}, 32'({m1_acknowledge, m0_acknowledge}), 32'(v.exp_grant));
        check({v.name, " grant_in_ack"}, 32'(grant), 32'(v.exp_grant));
        check({v.name, " s_bus_enable_in_ack"}, 32'(s_bus_enable), 32'd0);
        check({v.name, " m0_read_data"}, 32'(m0_read_data), 32'(v.exp_m0_rd));
        check({v.name, " m1_read_data"}, 32'(m1_read_data), 32'(v.exp_m1_rd));
        check({v.name, " timeout_err"}, 32'(timeout_err), 32'(v.exp_terr));
        if (v.exp_grant[0]) m0_bus_enable = 1'b0;
        if (v.exp_grant[1]) m1_bus_enable = 1'b0;
        err_clr = 1'b0;
        tick();
        check({v.name, " ack_single_pulse"}, 32'({m1_acknowledge, m0_acknowledge}), 32'd0);
        check({v.name, " grant_after"}, 32'(grant), 32'd0);
        $display("[TB] txn %-12s grant=%b cycles=%0d m0_rd=%h m1_rd=%h terr=%b",
                 v.name, v.exp_grant, c, m0_read_data, m1_read_data, timeout_err);
    endtask

    function automatic vec_t blank(input string nm);
        vec_t v;
        v.name = nm; v.m0_req = 0; v.m1_req = 0; v.m0_addr = '0; v.m1_addr = '0;
        v.m0_be = '0; v.m1_be = '0; v.m0_rw = 0; v.m1_rw = 0; v.m0_wd = '0; v.m1_wd = '0;
        v.clr = 0; v.ack_delay = -1; v.slave_rd = '0; v.exp_grant = '0; v.exp_addr = '0;
        v.exp_be = '0; v.exp_rw = 0; v.exp_wd = '0; v.exp_cycles = 0;
        v.exp_m0_rd = '0; v.exp_m1_rd = '0; v.exp_terr = 0;
        return v;
    endfunction

    task automatic check_all_zero(input string nm);
        check({nm, " s_bus_enable"}, 32'(s_bus_enable), 32'd0);
        check({nm, " grant"}, 32'(grant), 32'd0);
        check({nm, " s_address"}, 32'(s_address), 32'd0);
        check({nm, " s_write_data"}, 32'(s_write_data), 32'd0);
        check({nm, " m0_read_data"}, 32'(m0_read_data), 32'd0);
        check({nm, " m1_read_data"}, 32'(m1_read_data), 32'd0);
        check({nm, " acks"}, 32'({m1_acknowledge, m0_acknowledge}), 32'd0);
        check({nm, " m0_irq"}, 32'(m0_irq), 32'd0);
        check({nm, " timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        logic [15:0] rd0, rd1;

        // ---------------- vector table ----------------
        v = blank("m0_read");
        v.m0_req = 1; v.m0_addr = 11'h123; v.m0_be = 2'b11; v.m0_rw = 1; v.m0_wd = 16'h0000;
        v.ack_delay = 3; v.slave_rd = 16'hBEEF; v.exp_grant = 2'b01;
        v.exp_addr = 11'h123; v.exp_be = 2'b11; v.exp_rw = 1; v.exp_wd = 16'h0000;
        v.exp_cycles = 4; v.exp_m0_rd = 16'hBEEF; v.exp_m1_rd = 16'h0000;
        vecs.push_back(v);

        v = blank("m1_write");
        v.m1_req = 1; v.m1_addr = 11'h055; v.m1_be = 2'b10; v.m1_rw = 0; v.m1_wd = 16'hA5A5;
        v.ack_delay = 1; v.slave_rd = 16'h1111; v.exp_grant = 2'b10;
        v.exp_addr = 11'h055; v.exp_be = 2'b10; v.exp_rw = 0; v.exp_wd = 16'hA5A5;
        v.exp_cycles = 2; v.exp_m0_rd = 16'hBEEF; v.exp_m1_rd = 16'h0000;
        vecs.push_back(v);

        // Ten back-to-back contended transfers: last winner was m1, so m0 leads.
        rd0 = 16'hBEEF;
        rd1 = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            v = blank($sformatf("rr_%0d", k));
            v.m0_req = 1; v.m0_addr = 11'h200 + 11'(k); v.m0_be = 2'b11; v.m0_rw = 1;
            v.m0_wd = 16'h4000 + 16'(k);
            v.m1_req = 1; v.m1_addr = 11'h300 + 11'(k); v.m1_be = 2'b01;
            v.m1_rw = ((k % 4) == 1); v.m1_wd = 16'h5000 + 16'(k);
            v.ack_delay = k % 3; v.slave_rd = 16'h1000 + 16'(k);
            v.exp_cycles = (k % 3) + 1;
            if ((k % 2) == 0) begin
                v.exp_grant = 2'b01; v.exp_addr = v.m0_addr; v.exp_be = 2'b11;
                v.exp_rw = 1; v.exp_wd = v.m0_wd; rd0 = v.slave_rd;
            end else begin
                v.exp_grant = 2'b10; v.exp_addr = v.m1_addr; v.exp_be = 2'b01;
                v.exp_rw = v.m1_rw; v.exp_wd = v.m1_wd;
                if (v.m1_rw) rd1 = v.slave_rd;
            end
            v.exp_m0_rd = rd0; v.exp_m1_rd = rd1;
            vecs.push_back(v);
        end

        // Slave never answers; err_clr held high the whole time must not win.
        v = blank("timeout");
        v.m0_req = 1; v.m0_addr = 11'h0AA; v.m0_be = 2'b01; v.m0_rw = 1; v.m0_wd = 16'h0F0F;
        v.clr = 1; v.ack_delay = -1; v.slave_rd = 16'h7777; v.exp_grant = 2'b01;
        v.exp_addr = 11'h0AA; v.exp_be = 2'b01; v.exp_rw = 1; v.exp_wd = 16'h0F0F;
        v.exp_cycles = 8; v.exp_m0_rd = 16'hDEAD; v.exp_m1_rd = rd1; v.exp_terr = 1;
        vecs.push_back(v);

        // ---------------- reset ----------------
        reset_reset_n = 0; err_clr = 0; s_acknowledge = 0; s_read_data = '0; s_irq = 0;
        m0_bus_enable = 0; m0_address = '0; m0_byte_enable = '0; m0_rw = 0; m0_write_data = '0;
        m1_bus_enable = 0; m1_address = '0; m1_byte_enable = '0; m1_rw = 0; m1_write_data = '0;
        tick(); tick();
        check_all_zero("reset");
        reset_reset_n = 1;
        tick();

        foreach (vecs[i]) run_txn(vecs[i]);

        // ---------------- err_clr pulse clears the sticky flag ----------------
        err_clr = 1;
        tick();
        err_clr = 0;
        check("err_clr timeout_err", 32'(timeout_err), 32'd0);
        $display("[TB] txn err_clr      timeout_err=%b", timeout_err);

        // ---------------- ack on the expiry cycle: real data, no error ----------------
        v = blank("ack_at_expiry");
        v.m1_req = 1; v.m1_addr = 11'h7FF; v.m1_be = 2'b11; v.m1_rw = 1; v.m1_wd = 16'h0001;
        v.ack_delay = 7; v.slave_rd = 16'h5A5A; v.exp_grant = 2'b10;
        v.exp_addr = 11'h7FF; v.exp_be = 2'b11; v.exp_rw = 1; v.exp_wd = 16'h0001;
        v.exp_cycles = 8; v.exp_m0_rd = 16'hDEAD; v.exp_m1_rd = 16'h5A5A; v.exp_terr = 0;
        run_txn(v);

        // ---------------- stray s_acknowledge in IDLE is ignored ----------------
        s_acknowledge = 1; s_read_data = 16'h9999;
        tick(); tick();
        s_acknowledge = 0;
        check("stray_ack acks", 32'({m1_acknowledge, m0_acknowledge}), 32'd0);
        check("stray_ack s_bus_enable", 32'(s_bus_enable), 32'd0);
        check("stray_ack m1_read_data", 32'(m1_read_data), 32'h5A5A);
        $display("[TB] txn stray_ack    acks=%b%b", m1_acknowledge, m0_acknowledge);

        // ---------------- async reset in the middle of BUSY ----------------
        s_irq = 1;
        m1_bus_enable = 1; m1_address = 11'h321; m1_rw = 1; m1_byte_enable = 2'b11;
        tick();
        check("midreset busy s_bus_enable", 32'(s_bus_enable), 32'd1);
        check("midreset m0_irq before", 32'(m0_irq), 32'd1);
        #2;
        reset_reset_n = 0;
        #1;
        s_irq = 0;
        check_all_zero("midreset");
        m0_bus_enable = 1; m0_address = 11'h456; m0_rw = 0; m0_byte_enable = 2'b01;
        m0_write_data = 16'h2222;
        tick(); tick();
        check("midreset no_ack_held", 32'({m1_acknowledge, m0_acknowledge}), 32'd0);
        reset_reset_n = 1;
        tick();
        check("post_reset grant", 32'(grant), 32'd1);
        check("post_reset s_address", 32'(s_address), 32'h456);
        $display("[TB] txn mid_reset    grant=%b s_address=%h", grant, s_address);

        // ---------------- irq passes through one flop ----------------
        s_irq = 1;
        #1;
        check("irq not_yet", 32'(m0_irq), 32'd0);
        tick();
        check("irq rise", 32'(m0_irq), 32'd1);
        s_irq = 0;
        #1;
        check("irq held", 32'(m0_irq), 32'd1);
        tick();
        check("irq fall", 32'(m0_irq), 32'd0);
        $display("[TB] txn irq          m0_irq=%b", m0_irq);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_bridge_arbiter.md
Name: avalon_bridge_arbiter

Overview:
Two-master arbiter for the external 16-bit Avalon bridge bus: address[10:0], bus_enable, byte_enable[1:0], rw, write_data/read_data[15:0], acknowledge, irq. Master 0 is the Nios bridge port; master 1 is a hardware requester (DMA/test engine). The arbiter grants one master at a time using round-robin, registers the winning request onto the shared slave bus, and returns read data and a one-cycle acknowledge to the winner. A bus watchdog terminates hung transfers.

Parameters:
ADDR_W, 11, address width on all ports
DATA_W, 16, data width on all ports
BE_W, 2, byte-enable width
TIMEOUT, 255, max cycles in BUSY awaiting s_acknowledge (1..65535)
ERR_DATA, 16'hDEAD, read_data returned on timeout

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  async active-low reset
m0_address / m1_address  in  ADDR_W  master request address
m0_bus_enable / m1_bus_enable  in  1  request; held high with fields stable until mN_acknowledge
m0_byte_enable / m1_byte_enable  in  BE_W  byte lanes
m0_rw / m1_rw  in  1  1=read, 0=write
m0_write_data / m1_write_data  in  DATA_W  write data
m0_read_data / m1_read_data  out  DATA_W  read return, held until that master's next acknowledge
m0_acknowledge / m1_acknowledge  out  1  one-cycle completion pulse
m0_irq  out  1  s_irq passed through, registered
s_address  out  ADDR_W  shared bus address
s_bus_enable  out  1  shared bus strobe
s_byte_enable  out  BE_W
s_rw  out  1
s_write_data  out  DATA_W
s_read_data  in  DATA_W
s_acknowledge  in  1  slave completion
s_irq  in  1  slave interrupt
grant  out  2  one-hot current owner (status)
timeout_err  out  1  sticky watchdog flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=1 (m0 wins first contention), watchdog=0.
- States: IDLE, BUSY, ACK.
- IDLE: if any mN_bus_enable, pick the requester; when both request, pick the master not equal to last_grant. Capture its address/be/rw/wdata into s_* registers, set grant, last_grant. Next cycle s_bus_enable=1 (1-cycle request latency) -> BUSY.
- BUSY: s_* stable, watchdog increments each cycle. When s_acknowledge=1: if rw=1, latch s_read_data into the granted mN_read_data; pulse mN_acknowledge next cycle; drop s_bus_enable -> ACK. When watchdog reaches TIMEOUT with no ack, treat as completion: read_data=ERR_DATA (reads only), pulse ack, set timeout_err -> ACK. Ack and timeout in the same cycle: ack wins, no error.
- ACK: single cycle; mN_acknowledge=1, grant still held, s_bus_enable=0. Next state IDLE, grant=0. Master drops bus_enable by the following cycle; a master re-asserting immediately competes normally (round-robin prevents starvation).
- s_acknowledge outside BUSY is ignored.
- Writes do not alter mN_read_data.
- m0_irq = s_irq delayed one flop.
- timeout_err set has priority over err_clr in the same cycle.
- Reset mid-transfer: immediate return to reset values; no acknowledge is issued for the aborted transfer.
- Watchdog width is clog2(TIMEOUT+1); it is cleared on entry to BUSY.

Decomposition:
- Package avalon_bridge_pkg: ADDR_W/DATA_W/BE_W constants, state enum {IDLE,BUSY,ACK}, request struct {addr,be,rw,wdata}.
- Sub-module rr_arbiter2 for two-way round-robin selection from req[1:0] and last_grant; FSM, datapath and watchdog stay in the top level.

Test Plan:
- m0 read 0x123, slave acks 3 cycles after s_bus_enable with 0xBEEF -> s_bus_enable 1 cycle after request; m0_acknowledge pulses 1 cycle after s_ack; m0_read_data=0xBEEF; grant=01 during transfer.
- m1 write 0x055/0xA5A5, be=10 -> s_address=0x055, s_write_data=0xA5A5, s_byte_enable=10, s_rw=0; m1_read_data unchanged.
- Both request from reset, continuously -> grant order m0, m1, m0, m1; no starvation across 10 transfers.
- No slave ack, TIMEOUT=8 -> ack pulse after 8 BUSY cycles, read_data=0xDEAD, timeout_err=1; err_clr pulse -> 0.
- Ack in the same cycle the watchdog expires -> real data returned, timeout_err stays 0.
- reset_reset_n low during BUSY -> all outputs 0 asynchronously; after release m0 is granted first; s_irq toggle appears on m0_irq 1 cycle later.
